// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry layout and helpers for the reorder buffer.
// Optional feature macro: ROB_STATS_EN (commit/flush counters).
package reorder_buffer_pkg;
  localparam int ROB_WIDTH_BIT = 3;
  localparam int RD_W          = 5;
  localparam int VAL_W         = 32;
  localparam int PC_W          = 32;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            is_branch;
    logic            pred_taken;
    logic            taken;
    logic [PC_W-1:0] alt_pc;
  } rob_entry_t;

  function automatic logic mispredicted(input rob_entry_t e);
    return e.is_branch && (e.taken != e.pred_taken);
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / writeback / look-up / commit bus between the pipeline and the reorder buffer.
// Optional feature macro: ROB_STATS_EN adds stat_commits and stat_flushes.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(parameter int ROB_BITS = ROB_WIDTH_BIT);
  // issue_valid is a request without a ready: the entry is taken only when full and rob_clear
  // are low and the ROB is not stalled; the producer must watch full itself.
  logic                issue_valid;
  logic [RD_W-1:0]     issue_rd;
  logic                issue_is_branch;
  logic                issue_pred_taken;
  logic [PC_W-1:0]     issue_alt_pc;
  logic [ROB_BITS-1:0] issue_rob_id;
  logic                full;
  logic [RD_W-1:0]     set_dep_reg_id;
  logic [ROB_BITS-1:0] set_dep_rob_id;
  logic                wb_valid;
  logic [ROB_BITS-1:0] wb_rob_id;
  logic [VAL_W-1:0]    wb_val;
  logic                wb_taken;
  logic [ROB_BITS-1:0] get_rob_id1;
  logic [ROB_BITS-1:0] get_rob_id2;
  logic                rob_value1_ready;
  logic                rob_value2_ready;
  logic [VAL_W-1:0]    rob_value1;
  logic [VAL_W-1:0]    rob_value2;
  logic [RD_W-1:0]     set_reg_id;
  logic [VAL_W-1:0]    set_val;
  logic [ROB_BITS-1:0] set_reg_on_rob_id;
  logic                rob_clear;
  logic [PC_W-1:0]     clear_pc;
  logic [ROB_BITS:0]   dbg_count;
`ifdef ROB_STATS_EN
  logic [31:0]         stat_commits;
  logic [31:0]         stat_flushes;
`endif

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output wb_valid, wb_rob_id, wb_val, wb_taken, get_rob_id1, get_rob_id2,
    input  issue_rob_id, full, set_dep_reg_id, set_dep_rob_id,
    input  rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    input  set_reg_id, set_val, set_reg_on_rob_id, rob_clear, clear_pc, dbg_count
`ifdef ROB_STATS_EN
    , input stat_commits, stat_flushes
`endif
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  wb_valid, wb_rob_id, wb_val, wb_taken, get_rob_id1, get_rob_id2,
    output issue_rob_id, full, set_dep_reg_id, set_dep_rob_id,
    output rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    output set_reg_id, set_val, set_reg_on_rob_id, rob_clear, clear_pc, dbg_count
`ifdef ROB_STATS_EN
    , output stat_commits, stat_flushes
`endif
  );
endinterface

// File: rtl/reorder_buffer_lookup.sv
// Operand look-up by ROB id; a writeback to the same id this cycle is forwarded directly.
module reorder_buffer_lookup
  import reorder_buffer_pkg::*;
#(parameter int ROB_BITS = ROB_WIDTH_BIT) (
  input  logic [ROB_BITS-1:0]                  id,
  input  logic                                 wb_valid,
  input  logic [ROB_BITS-1:0]                  wb_rob_id,
  input  logic [VAL_W-1:0]                     wb_val,
  input  logic [(1<<ROB_BITS)-1:0]             ready_vec,
  input  logic [(1<<ROB_BITS)-1:0][VAL_W-1:0]  val_vec,
  output logic                                 ready,
  output logic [VAL_W-1:0]                     value
);
  logic hit;

  assign hit   = wb_valid && (wb_rob_id == id);
  assign ready = ready_vec[id] | hit;
  assign value = hit ? wb_val : val_vec[id];
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: rename at issue, operand look-up, in-order commit, mispredict flush.
// Optional feature macro: ROB_STATS_EN enables commit/flush counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(parameter int ROB_BITS = ROB_WIDTH_BIT) (
  input logic clk_in,
  input logic rst_n_in,
  input logic rdy_in,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 1 << ROB_BITS;
  typedef logic [ROB_BITS-1:0] id_t;
  typedef logic [ROB_BITS:0]   cnt_t;

  id_t                          head, tail, wb_off;
  cnt_t                         count;
  rob_entry_t                   ent [DEPTH];
  logic [DEPTH-1:0]             ready_vec;
  logic [DEPTH-1:0][VAL_W-1:0]  val_vec;
  rob_entry_t                   head_ent;
  logic                         full, commit, flush, alloc, wb_live;

  assign full = (count == cnt_t'(DEPTH));

  // A writeback landing on the head this cycle defers its commit by one cycle.
  always_comb begin
    head_ent = ent[head];
    wb_off   = rob.wb_rob_id - head;
    wb_live  = rdy_in && rob.wb_valid && !rob.rob_clear && ({1'b0, wb_off} < count);
    commit   = rdy_in && !rob.rob_clear && (count != '0) && ready_vec[head]
               && !(rob.wb_valid && (rob.wb_rob_id == head));
    flush    = commit && mispredicted(head_ent);
    alloc    = rdy_in && rob.issue_valid && !full && !rob.rob_clear && !flush;
  end

  assign rob.full           = full;
  assign rob.issue_rob_id   = tail;
  assign rob.set_dep_rob_id = tail;
  assign rob.set_dep_reg_id = alloc ? rob.issue_rd : '0;
  assign rob.dbg_count      = count;

  // Payload storage is never reset; the ready bits alone say whether it is meaningful.
  always_ff @(posedge clk_in) begin
    if (alloc) begin
      ent[tail] <= '{rd: rob.issue_rd, is_branch: rob.issue_is_branch,
                     pred_taken: rob.issue_pred_taken, taken: 1'b0, alt_pc: rob.issue_alt_pc};
    end
    if (wb_live) begin
      ent[rob.wb_rob_id].taken   <= rob.wb_taken;
      val_vec[rob.wb_rob_id]     <= rob.wb_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      ready_vec             <= '0;
      rob.set_reg_id        <= '0;
      rob.set_val           <= '0;
      rob.set_reg_on_rob_id <= '0;
      rob.rob_clear         <= 1'b0;
      rob.clear_pc          <= '0;
    end else if (rdy_in) begin
      rob.set_reg_id <= '0;
      rob.rob_clear  <= flush;
      if (commit && !head_ent.is_branch) begin
        rob.set_reg_id        <= head_ent.rd;
        rob.set_val           <= val_vec[head];
        rob.set_reg_on_rob_id <= head;
      end
      if (flush) rob.clear_pc <= head_ent.alt_pc;
      if (wb_live) ready_vec[rob.wb_rob_id] <= 1'b1;
      if (alloc) ready_vec[tail] <= 1'b0;
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        ready_vec <= '0;
      end else begin
        if (commit) head <= head + id_t'(1);
        if (alloc) tail <= tail + id_t'(1);
        if (alloc && !commit) count <= count + cnt_t'(1);
        else if (commit && !alloc) count <= count - cnt_t'(1);
      end
    end
  end

  reorder_buffer_lookup #(.ROB_BITS(ROB_BITS)) u_lookup1 (
    .id(rob.get_rob_id1), .wb_valid(rob.wb_valid), .wb_rob_id(rob.wb_rob_id), .wb_val(rob.wb_val),
    .ready_vec(ready_vec), .val_vec(val_vec), .ready(rob.rob_value1_ready), .value(rob.rob_value1)
  );

  reorder_buffer_lookup #(.ROB_BITS(ROB_BITS)) u_lookup2 (
    .id(rob.get_rob_id2), .wb_valid(rob.wb_valid), .wb_rob_id(rob.wb_rob_id), .wb_val(rob.wb_val),
    .ready_vec(ready_vec), .val_vec(val_vec), .ready(rob.rob_value2_ready), .value(rob.rob_value2)
  );

`ifdef ROB_STATS_EN
  logic [31:0] commits_q, flushes_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commits_q <= '0;
      flushes_q <= '0;
    end else if (rdy_in) begin
      if (commit) commits_q <= commits_q + 32'd1;
      if (flush) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign rob.stat_commits = commits_q;
  assign rob.stat_flushes = flushes_q;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised and directed bench for reorder_buffer against a queue-based reference model.
// Build with ROB_STATS_EN defined to also check the statistics counters.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int RB    = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [4:0]  reg_id;
    logic [31:0] val;
    logic [2:0]  on_id;
    logic        clr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;

  reorder_buffer_if #(.ROB_BITS(RB)) rob_bus ();

  reorder_buffer #(.ROB_BITS(RB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .rob(rob_bus)
  );

  always #5 clk = ~clk;

  // stimulus for the next cycle
  logic        iv = 0, ibr = 0, ipt = 0, wv = 0, wt = 0;
  logic [4:0]  ird = 0;
  logic [31:0] ialt = 0, wval = 0;
  logic [2:0]  wid = 0, g1 = 0, g2 = 0;

  // reference model: occupancy queue of ids, oldest first, plus per-slot contents
  int          occ[$];
  int          m_tail = 0;
  bit          m_ready [DEPTH];
  logic [31:0] m_val   [DEPTH];
  bit          m_taken [DEPTH];
  bit          m_br    [DEPTH];
  bit          m_pred  [DEPTH];
  logic [4:0]  m_rd    [DEPTH];
  logic [31:0] m_alt   [DEPTH];
  bit          m_clr = 0;
  logic [4:0]  m_reg = 0;
  logic [31:0] m_sval = 0, m_pc = 0;
  int          m_on = 0;
  int          m_commits = 0, m_flushes = 0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_occ(input int id);
    foreach (occ[i]) if (occ[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_model();
    occ.delete();
    m_tail = 0;
    foreach (m_ready[i]) m_ready[i] = 0;
    m_clr = 0; m_reg = 0; m_sval = 0; m_on = 0; m_pc = 0;
    m_commits = 0; m_flushes = 0;
  endtask

  task automatic idle();
    iv = 0; ibr = 0; ipt = 0; ird = 0; ialt = 0;
    wv = 0; wid = 0; wval = 0; wt = 0;
    g1 = 3'($urandom_range(0, 7)); g2 = 3'($urandom_range(0, 7));
    rdy = 1'b1;
  endtask

  // Drive one cycle (called at a falling edge), check the combinational outputs,
  // advance the model across the next rising edge and queue the registered outputs.
  task automatic step();
    int h;
    bit c, f, a, bp1, bp2;
    exp_t e;
    rob_bus.issue_valid = iv; rob_bus.issue_rd = ird; rob_bus.issue_is_branch = ibr;
    rob_bus.issue_pred_taken = ipt; rob_bus.issue_alt_pc = ialt;
    rob_bus.wb_valid = wv; rob_bus.wb_rob_id = wid; rob_bus.wb_val = wval; rob_bus.wb_taken = wt;
    rob_bus.get_rob_id1 = g1; rob_bus.get_rob_id2 = g2;
    #1;
    h = (occ.size() > 0) ? occ[0] : 0;
    c = rdy && !m_clr && (occ.size() > 0) && m_ready[h] && !(wv && (int'(wid) == h));
    f = c && m_br[h] && (m_taken[h] != m_pred[h]);
    a = rdy && iv && (occ.size() < DEPTH) && !m_clr && !f;
    check("full", 32'(rob_bus.full), 32'(occ.size() == DEPTH));
    check("issue_rob_id", 32'(rob_bus.issue_rob_id), m_tail);
    check("set_dep_rob_id", 32'(rob_bus.set_dep_rob_id), m_tail);
    check("set_dep_reg_id", 32'(rob_bus.set_dep_reg_id), a ? 32'(ird) : 32'd0);
    check("count", 32'(rob_bus.dbg_count), occ.size());
    bp1 = wv && (wid == g1);
    bp2 = wv && (wid == g2);
    check("value1_ready", 32'(rob_bus.rob_value1_ready), 32'(m_ready[g1] || bp1));
    check("value2_ready", 32'(rob_bus.rob_value2_ready), 32'(m_ready[g2] || bp2));
    if (m_ready[g1] || bp1) check("value1", rob_bus.rob_value1, bp1 ? wval : m_val[g1]);
    if (m_ready[g2] || bp2) check("value2", rob_bus.rob_value2, bp2 ? wval : m_val[g2]);
`ifdef ROB_STATS_EN
    check("stat_commits", rob_bus.stat_commits, m_commits);
    check("stat_flushes", rob_bus.stat_flushes, m_flushes);
`endif
    if (rdy) begin
      if (!m_clr && wv && is_occ(int'(wid))) begin
        m_ready[wid] = 1; m_val[wid] = wval; m_taken[wid] = wt;
      end
      m_reg = '0;
      if (c) begin
        void'(occ.pop_front());
        m_commits++;
        if (!m_br[h]) begin m_reg = m_rd[h]; m_sval = m_val[h]; m_on = h; end
      end
      if (a) begin
        occ.push_back(m_tail);
        m_ready[m_tail] = 0; m_rd[m_tail] = ird; m_br[m_tail] = ibr;
        m_pred[m_tail] = ipt; m_alt[m_tail] = ialt;
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_clr = f;
      if (f) begin
        m_pc = m_alt[h];
        m_flushes++;
        occ.delete();
        m_tail = 0;
        foreach (m_ready[i]) m_ready[i] = 0;
      end
    end
    e.reg_id = m_reg; e.val = m_sval; e.on_id = 3'(m_on); e.clr = m_clr; e.pc = m_pc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic pt, input logic [31:0] alt);
    idle(); iv = 1; ird = rd; ibr = br; ipt = pt; ialt = alt;
    step();
  endtask

  task automatic do_wb(input int id, input logic [31:0] v, input logic t);
    idle(); wv = 1; wid = 3'(id); wval = v; wt = t;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && occ.size() > 0; k++) begin
      idle();
      if (!m_ready[occ[0]]) begin
        wv = 1; wid = 3'(occ[0]); wval = $urandom; wt = m_pred[occ[0]];
      end
      step();
    end
    check("drain_done", occ.size(), 0);
  endtask

  // monitor: one expected record per driven cycle, compared after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("set_reg_id", 32'(rob_bus.set_reg_id), 32'(e.reg_id));
        if (e.reg_id != 0) begin
          check("set_val", rob_bus.set_val, e.val);
          check("set_reg_on_rob_id", 32'(rob_bus.set_reg_on_rob_id), 32'(e.on_id));
        end
        check("rob_clear", 32'(rob_bus.rob_clear), 32'(e.clr));
        if (e.clr) check("clear_pc", rob_bus.clear_pc, e.pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_set_reg_id"}, 32'(rob_bus.set_reg_id), 0);
    check({tag, "_set_val"}, rob_bus.set_val, 0);
    check({tag, "_set_reg_on_rob_id"}, 32'(rob_bus.set_reg_on_rob_id), 0);
    check({tag, "_rob_clear"}, 32'(rob_bus.rob_clear), 0);
    check({tag, "_clear_pc"}, rob_bus.clear_pc, 0);
    check({tag, "_full"}, 32'(rob_bus.full), 0);
    check({tag, "_issue_rob_id"}, 32'(rob_bus.issue_rob_id), 0);
    check({tag, "_count"}, 32'(rob_bus.dbg_count), 0);
`ifdef ROB_STATS_EN
    check({tag, "_stat_commits"}, rob_bus.stat_commits, 0);
    check({tag, "_stat_flushes"}, rob_bus.stat_flushes, 0);
`endif
  endtask

  initial begin
    int id0, id1;
    idle();
    step_inputs_only: begin
      rob_bus.issue_valid = 0; rob_bus.issue_rd = 0; rob_bus.issue_is_branch = 0;
      rob_bus.issue_pred_taken = 0; rob_bus.issue_alt_pc = 0;
      rob_bus.wb_valid = 0; rob_bus.wb_rob_id = 0; rob_bus.wb_val = 0; rob_bus.wb_taken = 0;
      rob_bus.get_rob_id1 = 0; rob_bus.get_rob_id2 = 0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // rename on issue, writeback, then commit
    do_issue(5'd5, 0, 0, 32'h0);
    do_wb(0, 32'h1234, 0);
    idle(); step();
    idle(); step();

    // bypass on a free slot, then the ignored writeback leaves it not ready
    idle(); wv = 1; wid = 3'd2; wval = 32'hBEEF; g1 = 3'd2; step();
    idle(); g1 = 3'd2; step();

    // fill, refused ninth issue, full-and-committing refusal, then wrap
    for (int i = 0; i < DEPTH; i++) do_issue(5'($urandom_range(1, 31)), 0, 0, 32'h0);
    do_issue(5'd9, 0, 0, 32'h0);
    do_wb(occ[0], 32'h55, 0);
    do_issue(5'd12, 0, 0, 32'h0);
    do_issue(5'd13, 0, 0, 32'h0);
    drain();

    // mispredicted branch discards the younger rd=7 entry
    do_issue(5'd0, 1, 0, 32'h100);
    do_issue(5'd7, 0, 0, 32'h0);
    do_wb(occ[0], 32'h0, 1);
    idle(); step();
    do_issue(5'd3, 0, 0, 32'h0);
    do_issue(5'd4, 0, 0, 32'h0);
    drain();

    // out-of-order writeback, stalled by rdy_in for three cycles
    do_issue(5'd10, 0, 0, 32'h0);
    do_issue(5'd11, 0, 0, 32'h0);
    id0 = occ[0]; id1 = occ[1];
    do_wb(id1, 32'hA1, 0);
    for (int k = 0; k < 3; k++) begin
      idle(); rdy = 1'b0; iv = 1; ird = 5'd20; wv = 1; wid = 3'(id0); wval = 32'hDEAD;
      step();
    end
    do_wb(id0, 32'hA0, 0);
    idle(); step();
    idle(); step();
    idle(); step();

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy  = ($urandom_range(0, 9) != 0);
      iv   = ($urandom_range(0, 1) == 1);
      ibr  = ($urandom_range(0, 4) == 0);
      ird  = ibr ? 5'd0 : 5'($urandom_range(0, 31));
      ipt  = 1'($urandom_range(0, 1));
      ialt = $urandom;
      wv   = ($urandom_range(0, 9) < 6);
      if (occ.size() > 0 && $urandom_range(0, 3) != 0)
        wid = 3'(occ[$urandom_range(0, occ.size() - 1)]);
      else
        wid = 3'($urandom_range(0, 7));
      wval = $urandom;
      wt   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) g1 = wid;
      step();
    end

    // asynchronous reset while a flush pulse is showing
    drain();
    do_issue(5'd0, 1, 1, 32'h200);
    do_wb(occ[0], 32'h0, 0);
    idle(); step();
    check("pre_reset_rob_clear", 32'(rob_bus.rob_clear), 32'(m_clr));
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    do_issue(5'd6, 0, 0, 32'h0);
    do_wb(0, 32'h77, 0);
    idle(); step();
    idle(); step();

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
